// File: rtl/video_timing_gen_if.sv
// Video timing bundle between the raster generator and its consumers.
// The generator takes the slave side; the core/video sink drives the master side.
interface video_timing_gen_if #(
  parameter int unsigned COLOR_W = 12
);
  logic               ce_pix;
  logic [4:0]         hoffs;
  logic [3:0]         voffs;
  logic [COLOR_W-1:0] rgb_in;
  logic [8:0]         hpos;
  logic [8:0]         vpos;
  logic [COLOR_W-1:0] rgb_out;
  logic               hblank;
  logic               vblank;
  logic               hsync;
  logic               vsync;
  logic               line_start;
  logic               frame_start;

  modport master (
    output ce_pix, hoffs, voffs, rgb_in,
    input  hpos, vpos, rgb_out, hblank, vblank, hsync, vsync,
           line_start, frame_start
  );

  modport slave (
    input  ce_pix, hoffs, voffs, rgb_in,
    output hpos, vpos, rgb_out, hblank, vblank, hsync, vsync,
           line_start, frame_start
  );
endinterface

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: pixel/line counters on ce_pix, registered
// blanking/sync/RGB, frame-latched signed sync offsets and line/frame strobes.
module video_timing_gen #(
  parameter int unsigned H_TOTAL      = 396,
  parameter int unsigned H_ACT_START  = 25,
  parameter int unsigned H_ACT_END    = 265,
  parameter int unsigned H_SYNC_START = 320,
  parameter int unsigned H_SYNC_LEN   = 31,
  parameter int unsigned V_TOTAL      = 256,
  parameter int unsigned V_ACT_END    = 224,
  parameter int unsigned V_SYNC_START = 226,
  parameter int unsigned V_SYNC_LEN   = 5,
  parameter int unsigned HPOS_BIAS    = 24,
  parameter int unsigned COLOR_W      = 12
) (
  input  logic             clk_sys,
  input  logic             reset,
  video_timing_gen_if.slave vid
);

  localparam int unsigned HW = $clog2(H_TOTAL);
  localparam int unsigned VW = $clog2(V_TOTAL);

  if (H_SYNC_LEN >= H_TOTAL) begin : g_bad_hsync_len
    $error("H_SYNC_LEN must be smaller than H_TOTAL");
  end
  if (V_SYNC_LEN >= V_TOTAL) begin : g_bad_vsync_len
    $error("V_SYNC_LEN must be smaller than V_TOTAL");
  end
  if (!(H_ACT_START < H_ACT_END && H_ACT_END <= H_TOTAL)) begin : g_bad_hact
    $error("need H_ACT_START < H_ACT_END <= H_TOTAL");
  end

  logic [HW-1:0]      hcnt_q, hcnt_d;
  logic [VW-1:0]      vcnt_q, vcnt_d;
  logic signed [4:0]  hoffs_q, hoffs_d;
  logic signed [3:0]  voffs_q, voffs_d;
  logic               hblank_q, hblank_d;
  logic               vblank_q, vblank_d;
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic               line_start_q, line_start_d;
  logic               frame_start_q, frame_start_d;
  logic [COLOR_W-1:0] rgb_q, rgb_d;

  logic line_end, last_line, hs_win, vs_win;

  // Window start/end are folded into [0,total) with one correction each; the
  // legal offset ranges keep start+offs within one total of the valid range.
  function automatic logic sync_win(input int cnt, input int start, input int offs,
                                    input int len, input int total);
    int b;
    int e;
    b = start + offs;
    if (b < 0) b = b + total;
    else if (b >= total) b = b - total;
    e = b + len;
    if (e >= total) e = e - total;
    if (b < e) return (cnt >= b) && (cnt < e);
    return (cnt >= b) || (cnt < e);
  endfunction

  assign line_end  = (int'(hcnt_q) == int'(H_TOTAL) - 1);
  assign last_line = (int'(vcnt_q) == int'(V_TOTAL) - 1);

  assign hs_win = sync_win(int'(hcnt_q), int'(H_SYNC_START), int'(hoffs_q),
                           int'(H_SYNC_LEN), int'(H_TOTAL));
  assign vs_win = sync_win(int'(vcnt_q), int'(V_SYNC_START), int'(voffs_q),
                           int'(V_SYNC_LEN), int'(V_TOTAL));

  always_comb begin
    hcnt_d        = hcnt_q;
    vcnt_d        = vcnt_q;
    hoffs_d       = hoffs_q;
    voffs_d       = voffs_q;
    hblank_d      = hblank_q;
    vblank_d      = vblank_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    line_start_d  = line_start_q;
    frame_start_d = frame_start_q;
    rgb_d         = rgb_q;
    if (vid.ce_pix) begin
      if (line_end) begin
        hcnt_d = '0;
        vcnt_d = last_line ? '0 : vcnt_q + VW'(1);
      end else begin
        hcnt_d = hcnt_q + HW'(1);
      end
      if (line_end && last_line) begin
        hoffs_d = $signed(vid.hoffs);
        voffs_d = $signed(vid.voffs);
      end
      // Flags sample the pre-increment counters, so they lag hcnt/vcnt by one ce.
      hblank_d      = (int'(hcnt_q) < int'(H_ACT_START)) || (int'(hcnt_q) >= int'(H_ACT_END));
      vblank_d      = (int'(vcnt_q) >= int'(V_ACT_END));
      hsync_d       = hs_win;
      vsync_d       = vs_win;
      rgb_d         = (hblank_d || vblank_d) ? '0 : vid.rgb_in;
      line_start_d  = (hcnt_q == '0);
      frame_start_d = (hcnt_q == '0) && (vcnt_q == '0);
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      hoffs_q       <= '0;
      voffs_q       <= '0;
      hblank_q      <= 1'b0;
      vblank_q      <= 1'b0;
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      rgb_q         <= '0;
    end else begin
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      hoffs_q       <= hoffs_d;
      voffs_q       <= voffs_d;
      hblank_q      <= hblank_d;
      vblank_q      <= vblank_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      rgb_q         <= rgb_d;
    end
  end

  assign vid.hpos        = 9'(hcnt_q) - 9'(HPOS_BIAS);
  assign vid.vpos        = 9'(vcnt_q);
  assign vid.rgb_out     = rgb_q;
  assign vid.hblank      = hblank_q;
  assign vid.vblank      = vblank_q;
  assign vid.hsync       = hsync_q;
  assign vid.vsync       = vsync_q;
  assign vid.line_start  = line_start_q;
  assign vid.frame_start = frame_start_q;

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Parametrised raster timing generator for arcade cores. Successor to the fixed 396x256 generator.
- Counts pixels and lines on a pixel clock-enable in the system clock domain. Outputs pixel/line positions to the game core, plus registered blanking, sync and blanked RGB toward arcade_video.
- Adds over the fixed generator: configurable geometry and colour width, signed H/V sync offsets latched only at frame start (no mid-frame tearing), sync windows that wrap around the line/frame end, and line/frame start strobes.

Parameters:
- H_TOTAL, 396, pixels per line (counter wraps at H_TOTAL-1)
- H_ACT_START, 25, first active pixel count
- H_ACT_END, 265, first blanked pixel count after active
- H_SYNC_START, 320, nominal hsync start count
- H_SYNC_LEN, 31, hsync width in pixels
- V_TOTAL, 256, lines per frame
- V_ACT_END, 224, first blanked line (active lines are 0..V_ACT_END-1)
- V_SYNC_START, 226, nominal vsync start line
- V_SYNC_LEN, 5, vsync width in lines
- HPOS_BIAS, 24, subtracted from the pixel count to form hpos
- COLOR_W, 12, RGB bus width

Ports:
- clk_sys in 1: system clock
- reset in 1: asynchronous, active-high
- ce_pix in 1: pixel clock enable; all state advances only when high
- hoffs in 5: signed H sync offset (-16..15)
- voffs in 4: signed V sync offset (-8..7)
- rgb_in in COLOR_W: pixel colour from the core
- hpos out 9: hcnt - HPOS_BIAS, modulo 512 (combinational from hcnt)
- vpos out 9: vcnt, zero-extended
- rgb_out out COLOR_W: registered, zero while blanked
- hblank out 1: registered
- vblank out 1: registered
- hsync out 1: registered, active-high
- vsync out 1: registered, active-high
- line_start out 1: one-ce_pix pulse
- frame_start out 1: one-ce_pix pulse

Behaviour:
- Reset (async):
  - hcnt=0, vcnt=0.
  - Latched offsets hoffs_l=0, voffs_l=0.
  - All outputs 0 (rgb_out=0, hblank=vblank=hsync=vsync=line_start=frame_start=0).
- Counters, on ce_pix only:
  - If hcnt<H_TOTAL-1, hcnt++.
  - Otherwise hcnt=0 and vcnt=(vcnt==V_TOTAL-1)?0:vcnt+1.
- Offset latch: on ce_pix with hcnt==H_TOTAL-1 and vcnt==V_TOTAL-1, hoffs_l<=hoffs and voffs_l<=voffs. Offset changes at any other time have no effect until the next frame boundary.
- Sync window arithmetic:
  - hs_b=(H_SYNC_START+sext(hoffs_l)) mod H_TOTAL.
  - hs_e=(hs_b+H_SYNC_LEN) mod H_TOTAL.
  - Active when hs_b<=hcnt<hs_e if hs_b<hs_e; otherwise when hcnt>=hs_b or hcnt<hs_e (wrap case).
  - Vertical uses the same rules with V_* parameters, voffs_l and vcnt.
  - Modulo is done by a single conditional add/subtract of the total. Legal ranges guarantee one correction suffices.
- Registered outputs, on ce_pix, sampled from the pre-increment counters (one ce_pix latency vs hcnt/vcnt):
  - hblank <= (hcnt<H_ACT_START)|(hcnt>=H_ACT_END)
  - vblank <= vcnt>=V_ACT_END
  - hsync, vsync <= window results above
  - rgb_out <= (next hblank | next vblank) ? 0 : rgb_in, so rgb_out aligns with the blank flags of the same cycle
  - line_start <= (hcnt==0); frame_start <= (hcnt==0 & vcnt==0)
- Without ce_pix: all registers hold; pulses stay high until the next ce_pix (width = one ce period).
- Reset mid-frame: counters restart at 0; the first ce_pix after release raises line_start and frame_start.
- Elaboration checks: H_SYNC_LEN<H_TOTAL, V_SYNC_LEN<V_TOTAL, H_ACT_START<H_ACT_END<=H_TOTAL.

Test Plan:
- Default parameters, hoffs=voffs=0, ce_pix every 8 clk_sys:
  - Expect 396 ce per line and 256 lines per frame.
  - hblank low for exactly hcnt 25..264 (240 pixels).
  - hsync high 31 pixels starting one ce after hcnt=320.
  - vsync lines 226..230.
- hpos check: at hcnt=0, hpos=488 (9'h1E8); at hcnt=24, hpos=0.
- hoffs=+15 → hs_b=335, hs_e=366. hoffs=-16 → hs_b=304.
- Wrap case with H_SYNC_START=380, hoffs=+15 → hs_b=395, hs_e=30. Expect hsync high for hcnt 395 and 0..29.
- Offset latching: change voffs from 0 to 7 at vcnt=100. vsync stays at lines 226..230 in the current frame and moves to 233..237 in the next frame.
- Blank RGB: rgb_in=12'hFFF constant. rgb_out=0 whenever hblank|vblank, else FFF.
- frame_start: one pulse per 101376 ce_pix.
- Reset asserted at vcnt=150: all outputs go 0 immediately. After release, the first ce_pix gives frame_start=1 and line_start=1.
